// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding, pattern-width limit and saturating increment for seq_detector_param
package seq_det_pkg;
  typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_LOCKED = 2'd2} state_t;
  localparam int MAX_PAT_W = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_shift_window.sv
// seq_shift_window: history shift register and saturating fill counter for the pattern detector
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         consume,
  input  logic         in,
  input  logic         restart,
  input  logic         clear,
  output logic [W-1:0] next_history,
  output logic         full,
  output logic         almost_full
);
  localparam int FW = $clog2(MAX_PAT_W + 1);
  logic [W-1:0]  history;
  logic [FW-1:0] fill;
  assign next_history = {history[W-2:0], in};
  assign full = fill == FW'(W);
  assign almost_full = fill == FW'(W - 1);
  // restart only rewinds the fill count; the shifted-in bit still lands in history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else begin
      history <= clear ? '0 : consume ? next_history : history;
      fill    <= (clear || restart) ? '0 : (consume && !full) ? fill + 1'b1 : fill;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector; SEQ_DET_MASK_EN adds a don't-care mask
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pattern_mask,
`endif
  input  logic             pattern_load,
  input  logic             overlap,
  input  logic             lock_mode,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             locked
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  state_t state, state_d;
  logic [PAT_W-1:0] target, mask, next_history;
  logic full, almost_full, consume, hit, restart;
  seq_shift_window #(.W(PAT_W)) u_win (
    .clk(clk), .rst(rst), .consume(consume), .in(in), .restart(restart), .clear(clear),
    .next_history(next_history), .full(full), .almost_full(almost_full)
  );
`ifdef SEQ_DET_MASK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mask <= '1;
    else if (pattern_load) mask <= pattern_mask;
  end
`else
  assign mask = '1;
`endif
  assign locked = state == ST_LOCKED;
  always_comb begin
    consume = in_valid && !clear && !pattern_load && state != ST_LOCKED;
    hit     = consume && (full || almost_full) && (((next_history ^ target) & mask) == '0);
    restart = clear || pattern_load || (hit && !lock_mode && !overlap);
    state_d = (clear || pattern_load) ? ST_FILL :
              hit ? (lock_mode ? ST_LOCKED : overlap ? ST_RUN : ST_FILL) :
              (consume && (full || almost_full)) ? ST_RUN : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FILL;
      target      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_d;
      target      <= pattern_load ? pattern : target;
      match       <= hit;
      match_count <= clear ? '0 : hit ? CNT_W'(sat_inc(32'(match_count), CNT_MAX)) : match_count;
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for seq_detector_param (default PAT_W=4, CNT_W=8)
module tb_seq_detector_param;
  logic clk = 0, rst = 0, in_valid = 0, in = 0, pattern_load = 0, overlap = 0, lock_mode = 0, clear = 0;
  logic [3:0] pattern = '0;
  logic [3:0] pattern_mask = '1;
  logic match, locked;
  logic [7:0] match_count;
  int checks = 0, errors = 0;
  logic exp_q[$];
  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .pattern(pattern),
`ifdef SEQ_DET_MASK_EN
    .pattern_mask(pattern_mask),
`endif
    .pattern_load(pattern_load), .overlap(overlap), .lock_mode(lock_mode), .clear(clear),
    .match(match), .match_count(match_count), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input logic exp);
    exp_q.push_back(exp);
    in_valid = 1;
    in = b;
    tick();
    in_valid = 0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else check("match", {31'd0, match}, {31'd0, exp_q.pop_front()});
  endtask
  task automatic load(input logic [3:0] p, input logic [3:0] m);
    pattern = p;
    pattern_mask = m;
    pattern_load = 1;
    tick();
    pattern_load = 0;
  endtask
  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", {31'd0, match}, 0);
    check("rst_count", {24'd0, match_count}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    rst = 1;
    tick();
    // overlapping: 1011 then 011 reuses the trailing 1
    overlap = 1;
    load(4'b1011, 4'b1111);
    send(1, 0); send(0, 0); send(1, 0); send(1, 1); send(0, 0); send(1, 0); send(1, 1);
    check("ovl_count", {24'd0, match_count}, 2);
    do_clear();
    check("clr_count", {24'd0, match_count}, 0);
    overlap = 0;
    send(1, 0); send(0, 0); send(1, 0); send(1, 1); send(0, 0); send(1, 0); send(1, 0);
    check("novl_count", {24'd0, match_count}, 1);
    // idle cycle between bits
    do_clear();
    send(1, 0); send(0, 0); send(1, 0);
    tick();
    check("idle_match", {31'd0, match}, 0);
    send(1, 1);
    // a bit presented with clear must be dropped
    do_clear();
    in_valid = 1;
    in = 1;
    clear = 1;
    tick();
    clear = 0;
    in_valid = 0;
    send(0, 0); send(1, 0); send(1, 0); send(0, 0);
    check("drop_count", {24'd0, match_count}, 0);
    // lock on first match
    do_clear();
    lock_mode = 1;
    overlap = 1;
    load(4'b0000, 4'b1111);
    send(0, 0); send(0, 0); send(0, 0); send(0, 1); send(0, 0);
    check("lock_locked", {31'd0, locked}, 1);
    check("lock_count", {24'd0, match_count}, 1);
    do_clear();
    check("unlock_locked", {31'd0, locked}, 0);
    check("unlock_count", {24'd0, match_count}, 0);
    // saturate the counter
    lock_mode = 0;
    for (int i = 0; i < 258; i++) send(0, i >= 3);
    check("sat_count", {24'd0, match_count}, 255);
    send(0, 1);
    check("sat_hold", {24'd0, match_count}, 255);
    // mask compare
    do_clear();
    load(4'b1001, 4'b1001);
`ifdef SEQ_DET_MASK_EN
    send(1, 0); send(1, 0); send(1, 0); send(1, 1);
`else
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
`endif
    // asynchronous reset mid-stream
    do_clear();
    load(4'b1011, 4'b1111);
    send(1, 0); send(0, 0); send(1, 0);
    #2 rst = 0;
    #1;
    check("arst_match", {31'd0, match}, 0);
    check("arst_count", {24'd0, match_count}, 0);
    check("arst_locked", {31'd0, locked}, 0);
    tick();
    rst = 1;
    send(1, 0);
    send(0, 0); send(1, 0); send(1, 0);
    load(4'b1011, 4'b1111);
    send(1, 0); send(0, 0); send(1, 0); send(1, 1);
    check("reload_count", {24'd0, match_count}, 1);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
